// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl -- run controller for the pipelined MIPS simulation bench.
//
// Sequences the core reset, counts RUN cycles, ends a run on halt (fetch PC
// stuck for STALL_LIMIT cycles) or on timeout (MAX_CYCLES), and buffers
// register-writeback events in a trace FIFO drained over valid/ready.
//
// Build option: define RUN_CTRL_TRACE_EN to build the trace FIFO, the
// handshake and the drop counter. Without it the trace outputs and `dropped`
// are tied to 0, `tr_ready` is ignored and DRAIN lasts a single cycle.
//
// Ports
//   clk, reset       system clock; asynchronous active-low reset
//   start            one-cycle pulse, accepted in IDLE or DONE only
//   core_reset       active-high reset to the core (low only in RUN)
//   pc_now           core fetch PC, watched for the halt condition
//   wb_en/pc/addr/data  writeback event from the core
//   tr_valid/ready, tr_pc/addr/data  trace output (FIFO head, registered)
//   running, done    state flags for RUN and DONE
//   halted, timeout  run-end cause, sticky until the next start
//   cycles           RUN cycles elapsed
//   dropped          trace events lost to a full FIFO (saturating)
module mips_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 2000,
  parameter int STALL_LIMIT  = 8,
  parameter int CNT_W        = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             core_reset,
  input  logic [31:0]      pc_now,
  input  logic             wb_en,
  input  logic [31:0]      wb_pc,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [31:0]      tr_pc,
  output logic [4:0]       tr_addr,
  output logic [31:0]      tr_data,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] dropped
);

  localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_t;

  state_t             state;
  logic [RST_W-1:0]   rst_cnt;
  logic [STALL_W-1:0] stall;
  logic [31:0]        pc_prev;
  logic               fifo_empty;
  logic               halt_hit, to_hit;

  // Both end conditions look at registered counters; halt takes priority.
  assign halt_hit = (stall == STALL_W'(STALL_LIMIT - 1));
  assign to_hit   = (cycles == CNT_W'(MAX_CYCLES - 1));

  // ---------------------------------------------------------------------
  // Run sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
      stall      <= '0;
      rst_cnt    <= '0;
      pc_prev    <= '0;
    end else begin
      pc_prev <= pc_now;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RESET;
            done    <= 1'b0;
            halted  <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
            stall   <= '0;
            rst_cnt <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        S_RUN: begin
          // The ending cycle still counts, so a timeout leaves cycles == MAX_CYCLES.
          cycles <= cycles + CNT_W'(1);
          stall  <= (pc_now == pc_prev) ? stall + STALL_W'(1) : '0;
          if (halt_hit || to_hit) begin
            state      <= S_DRAIN;
            core_reset <= 1'b1;
            running    <= 1'b0;
            halted     <= halt_hit;
            timeout    <= !halt_hit;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RUN_CTRL_TRACE_EN
  // ---------------------------------------------------------------------
  // Trace FIFO with a registered head: tr_* come straight from flops and
  // only change on a pop or when an empty FIFO takes its first entry.
  // ---------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);

  trace_t [FIFO_DEPTH-1:0] mem;
  trace_t                  head;
  trace_t                  wb_ent;
  logic [AW-1:0]           wr_ptr, rd_ptr, rd_next;
  logic [AW:0]             cnt, cnt_left;
  logic                    clr, push_req, full, pop, push_ok, drop;

  assign clr      = start && ((state == S_IDLE) || (state == S_DONE));
  assign push_req = (state == S_RUN) && wb_en && (wb_addr != 5'd0);
  assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop      = tr_valid && tr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign cnt_left = cnt - (AW+1)'(pop);
  assign rd_next  = rd_ptr + AW'(pop);
  assign wb_ent   = '{pc: wb_pc, addr: wb_addr, data: wb_data};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wb_ent;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      tr_valid <= 1'b0;
      head     <= '0;
      dropped  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      tr_valid <= 1'b0;
      head     <= '0;
      dropped  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_next;
      cnt      <= cnt_left + (AW+1)'(push_ok);
      tr_valid <= (cnt_left != '0) || push_ok;
      // With entries left after the pop the next head is already in storage
      // (it can never be the slot being written); otherwise it is the push.
      if (cnt_left != '0) head <= mem[rd_next];
      else if (push_ok)   head <= wb_ent;
      if (drop && (dropped != '1)) dropped <= dropped + CNT_W'(1);
    end
  end

  assign fifo_empty = (cnt == '0);
  assign tr_pc      = head.pc;
  assign tr_addr    = head.addr;
  assign tr_data    = head.data;
`else
  // Trace path not built: outputs tied off, DRAIN always sees an empty FIFO.
  logic unused_trace;
  assign unused_trace = ^{tr_ready, wb_en, wb_pc, wb_addr, wb_data};
  assign fifo_empty   = 1'b1;
  assign tr_valid     = 1'b0;
  assign tr_pc        = '0;
  assign tr_addr      = '0;
  assign tr_data      = '0;
  assign dropped      = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl (default parameters). Inputs are driven
// and outputs sampled on the falling edge; run cycle k is the k-th cycle
// with the DUT in RUN. Expectations follow the build option in effect.
module tb_mips_run_ctrl;

`ifdef RUN_CTRL_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        core_reset;
  logic [31:0] pc_now = 32'hBFC0_0000;
  logic        wb_en = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [31:0] tr_pc;
  logic [4:0]  tr_addr;
  logic [31:0] tr_data;
  logic        running, done, halted, timeout;
  logic [31:0] cycles, dropped;

  int nvec = 0;
  int nerr = 0;

  mips_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .core_reset(core_reset),
    .pc_now(pc_now), .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr),
    .wb_data(wb_data), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data),
    .running(running), .done(done), .halted(halted), .timeout(timeout),
    .cycles(cycles), .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_pc, wb_data;
    logic        tv, ck;
    logic [31:0] tpc;
    logic [4:0]  taddr;
    logic [31:0] tdata;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of run cycle 0.
  task automatic start_run();
    pc_now = 32'hBFC0_0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("rst_c1_core_reset", 32'(core_reset), 1);
    chk("rst_c1_running", 32'(running), 0);
    chk("rst_c1_done", 32'(done), 0);
    chk("rst_c1_halted", 32'(halted), 0);
    chk("rst_c1_timeout", 32'(timeout), 0);
    chk("rst_c1_cycles", cycles, 0);
    chk("rst_c1_dropped", dropped, 0);
    chk("rst_c1_tr_valid", 32'(tr_valid), 0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_c%0d_core_reset", i), 32'(core_reset), 1);
    end
    @(negedge clk);
  endtask

  // Drive pc_k = 0x3000 + 4*min(k,f) from run cycle k0 through the last RUN
  // cycle e, then check DRAIN and DONE. A stray start at k==3 must be ignored;
  // a writeback offered in DRAIN must not be traced.
  task automatic run_pc(input int k0, input int f, input int e, input logic xh, input logic xt);
    for (int k = k0; k <= e; k++) begin
      if (k == 0) begin
        chk("run0_core_reset", 32'(core_reset), 0);
        chk("run0_running", 32'(running), 1);
        chk("run0_cycles", cycles, 0);
      end
      if (k == 10) chk("run10_cycles", cycles, 10);
      if (k == e) begin
        chk("last_run_running", 32'(running), 1);
        chk("last_run_cycles", cycles, 32'(e));
      end
      start  = (k == 3);
      pc_now = 32'h3000 + 32'(4 * ((k < f) ? k : f));
      @(negedge clk);
    end
    start = 1'b0;
    chk("drain_running", 32'(running), 0);
    chk("drain_core_reset", 32'(core_reset), 1);
    chk("drain_halted", 32'(halted), 32'(xh));
    chk("drain_timeout", 32'(timeout), 32'(xt));
    chk("drain_cycles", cycles, 32'(e + 1));
    chk("drain_done", 32'(done), 0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_pc = 32'h3100; wb_data = 32'h1;
    @(negedge clk);
    chk("done_flag", 32'(done), 1);
    chk("done_tr_valid", 32'(tr_valid), 0);
    chk("done_cycles", cycles, 32'(e + 1));
    wb_en = 1'b0;
    @(negedge clk);
    chk("done_hold", 32'(done), 1);
    chk("done_tr_valid2", 32'(tr_valid), 0);
    chk("done_halted_hold", 32'(halted), 32'(xh));
  endtask

  initial begin
    // Trace order/filter vectors: inputs for run cycle k, outputs seen in k.
`ifdef RUN_CTRL_TRACE_EN
    tbl[0] = '{1'b1, 5'd1,  32'h3000, 32'h11,   1'b0, 1'b0, 32'h0,    5'd0,  32'h0,    0};
    tbl[1] = '{1'b1, 5'd0,  32'h3004, 32'hDEAD, 1'b1, 1'b1, 32'h3000, 5'd1,  32'h11,   1};
    tbl[2] = '{1'b1, 5'd31, 32'h3008, 32'h300C, 1'b0, 1'b0, 32'h0,    5'd0,  32'h0,    2};
    tbl[3] = '{1'b0, 5'd5,  32'h300C, 32'hBEEF, 1'b1, 1'b1, 32'h3008, 5'd31, 32'h300C, 3};
    tbl[4] = '{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 1'b0, 32'h0,    5'd0,  32'h0,    4};
    tbl[5] = '{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 1'b0, 32'h0,    5'd0,  32'h0,    5};
`else
    tbl[0] = '{1'b1, 5'd1,  32'h3000, 32'h11,   1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 0};
    tbl[1] = '{1'b1, 5'd0,  32'h3004, 32'hDEAD, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 1};
    tbl[2] = '{1'b1, 5'd31, 32'h3008, 32'h300C, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 2};
    tbl[3] = '{1'b0, 5'd5,  32'h300C, 32'hBEEF, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 3};
    tbl[4] = '{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 4};
    tbl[5] = '{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 5};
`endif

    // Power-on reset
    #1 reset = 1'b0;
    #1;
    chk("por_core_reset", 32'(core_reset), 1);
    chk("por_running", 32'(running), 0);
    chk("por_done", 32'(done), 0);
    chk("por_halted", 32'(halted), 0);
    chk("por_timeout", 32'(timeout), 0);
    chk("por_cycles", cycles, 0);
    chk("por_dropped", dropped, 0);
    chk("por_tr_valid", 32'(tr_valid), 0);
    chk("por_tr_pc", tr_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_core_reset", 32'(core_reset), 1);
    chk("idle_running", 32'(running), 0);

    // Halt: pc sticks at 0x3010 from run cycle 4; halt ends cycle 12.
    start_run();
    run_pc(0, 4, 12, 1'b1, 1'b0);

    // Timeout: pc changes every cycle; restart from DONE.
    start_run();
    run_pc(0, 100000, 1999, 1'b0, 1'b1);

    // Halt and timeout in the same cycle: halt wins.
    start_run();
    run_pc(0, 1991, 1999, 1'b1, 1'b0);

    // Trace order and $0 filtering with tr_ready held high.
    tr_ready = 1'b1;
    start_run();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("tbl%0d_tr_valid", k), 32'(tr_valid), 32'(tbl[k].tv));
      if (tbl[k].ck) begin
        chk($sformatf("tbl%0d_tr_pc", k), tr_pc, tbl[k].tpc);
        chk($sformatf("tbl%0d_tr_addr", k), 32'(tr_addr), 32'(tbl[k].taddr));
        chk($sformatf("tbl%0d_tr_data", k), tr_data, tbl[k].tdata);
      end
      chk($sformatf("tbl%0d_cycles", k), cycles, tbl[k].cyc);
      pc_now  = 32'h3000 + 32'(4 * k);
      wb_en   = tbl[k].wb_en;
      wb_addr = tbl[k].wb_addr;
      wb_pc   = tbl[k].wb_pc;
      wb_data = tbl[k].wb_data;
      @(negedge clk);
    end
    wb_en = 1'b0;
    run_pc(6, 5, 13, 1'b1, 1'b0);
    chk("trace_dropped", dropped, 0);

    // Overflow: 20 pushes into 16 entries with tr_ready low; halt ends cycle 27.
    tr_ready = 1'b0;
    start_run();
    for (int k = 0; k <= 27; k++) begin
      if (k == 20) begin
        chk("ovf_dropped", dropped, TR ? 32'd4 : 32'd0);
        chk("ovf_tr_valid", 32'(tr_valid), 32'(TR));
        chk("ovf_head_pc", tr_pc, TR ? 32'h4000 : 32'h0);
      end
      if (k == 25) chk("ovf_head_stable", tr_data, TR ? 32'hA000 : 32'h0);
      pc_now  = 32'h3000 + 32'(4 * ((k < 19) ? k : 19));
      wb_en   = (k < 20);
      wb_addr = 5'((k % 31) + 1);
      wb_pc   = 32'h4000 + 32'(4 * k);
      wb_data = 32'hA000 + 32'(k);
      @(negedge clk);
    end
    wb_en = 1'b0;
    chk("ovf_drain_halted", 32'(halted), 1);
    chk("ovf_drain_cycles", cycles, 28);
    chk("ovf_drain_done", 32'(done), 0);
    @(negedge clk);
`ifdef RUN_CTRL_TRACE_EN
    chk("ovf_wait_done", 32'(done), 0);
    tr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pop%0d_valid", i), 32'(tr_valid), 1);
      chk($sformatf("pop%0d_pc", i), tr_pc, 32'h4000 + 32'(4 * i));
      chk($sformatf("pop%0d_addr", i), 32'(tr_addr), 32'(i + 1));
      chk($sformatf("pop%0d_data", i), tr_data, 32'hA000 + 32'(i));
      @(negedge clk);
    end
    chk("ovf_empty_valid", 32'(tr_valid), 0);
    chk("ovf_empty_done", 32'(done), 0);
    @(negedge clk);
    chk("ovf_done", 32'(done), 1);
    chk("ovf_done_dropped", dropped, 4);
    chk("ovf_done_cycles", cycles, 28);
    tr_ready = 1'b0;
`else
    chk("ovf_done", 32'(done), 1);
    chk("ovf_done_valid", 32'(tr_valid), 0);
    chk("ovf_done_dropped", dropped, 0);
`endif

    // Asynchronous reset in the middle of RUN, with a trace entry pending.
    start_run();
    wb_en = 1'b1; wb_addr = 5'd2; wb_pc = 32'h3000; wb_data = 32'h55; pc_now = 32'h3000;
    @(negedge clk);
    wb_en = 1'b0; pc_now = 32'h3004;
    @(negedge clk);
    pc_now = 32'h3008;
    chk("ar_pre_valid", 32'(tr_valid), 32'(TR));
    chk("ar_pre_cycles", cycles, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_core_reset", 32'(core_reset), 1);
    chk("ar_tr_valid", 32'(tr_valid), 0);
    chk("ar_cycles", cycles, 0);
    chk("ar_running", 32'(running), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_idle_running", 32'(running), 0);
    chk("ar_idle_done", 32'(done), 0);
    chk("ar_idle_core_reset", 32'(core_reset), 1);

    // A start from IDLE after the reset runs normally.
    start_run();
    run_pc(0, 4, 12, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
